// File: rtl/awgn_channel.sv
`default_nettype none
// ============================================================================
// awgn_channel : buffers bm_rng noise pairs, scales by sigma, adds to signal
// Revision     : 1.0
// ============================================================================
module awgn_channel #(
  parameter int NOISE_DEPTH = 8,
  parameter int CNT_W       = 16
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             noise_valid,
  input  logic [15:0]                      noise_x0,
  input  logic [15:0]                      noise_x1,
  input  logic [15:0]                      sigma,
  input  logic                             in_valid,
  input  logic [15:0]                      in_data,
  output logic                             in_ready,
  output logic                             out_valid,
  output logic [15:0]                      out_data,
  output logic                             out_sat,
  input  logic                             out_ready,
  output logic [$clog2(NOISE_DEPTH):0]     noise_level,
  output logic [CNT_W-1:0]                 drop_count,
  output logic [CNT_W-1:0]                 sat_count
);

  localparam int PTR_W = $clog2(NOISE_DEPTH);
  localparam int LVL_W = PTR_W + 1;

  logic [15:0]       r_mem [NOISE_DEPTH];
  logic [PTR_W-1:0]  r_wr_ptr;
  logic [PTR_W-1:0]  r_rd_ptr;
  logic [LVL_W-1:0]  r_level;

  logic              r_s1_valid;
  logic [15:0]       r_s1_data;
  logic [15:0]       r_s1_noise;
  logic [15:0]       r_s1_sigma;

  logic              w_push;
  logic              w_pop;
  logic              w_adv1;
  logic              w_adv2;
  logic [PTR_W-1:0]  w_wr_ptr1;
  logic signed [32:0] w_prod;
  logic signed [32:0] w_sum;
  logic              w_sat_hi;
  logic              w_sat_lo;
  logic [15:0]       w_res;

  // Room for a whole pair is judged on the pre-pop level so pairs never split.
  assign w_push    = noise_valid && (r_level <= LVL_W'(NOISE_DEPTH - 2));
  assign w_adv2    = !out_valid || out_ready;
  assign w_adv1    = !r_s1_valid || w_adv2;
  assign in_ready  = (r_level != '0) && w_adv1;
  assign w_pop     = in_valid && in_ready;
  assign w_wr_ptr1 = r_wr_ptr + PTR_W'(1);

  assign noise_level = r_level;

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr]  <= noise_x0;
      r_mem[w_wr_ptr1] <= noise_x1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_level    <= '0;
      drop_count <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + PTR_W'(2);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      end
      r_level <= r_level + LVL_W'(w_push ? 2 : 0) - LVL_W'(w_pop ? 1 : 0);
      if (noise_valid && !w_push && (drop_count != '1)) begin
        drop_count <= drop_count + CNT_W'(1);
      end
    end
  end

  // Stage 1: capture operands at the input handshake.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_s1_valid <= 1'b0;
      r_s1_data  <= '0;
      r_s1_noise <= '0;
      r_s1_sigma <= '0;
    end else if (w_adv1) begin
      r_s1_valid <= w_pop;
      if (w_pop) begin
        r_s1_data  <= in_data;
        r_s1_noise <= r_mem[r_rd_ptr];
        r_s1_sigma <= sigma;
      end
    end
  end

  // The sum is kept at product width; its range never exceeds 20 bits,
  // so saturation against 16-bit limits behaves exactly as a 20-bit adder.
  assign w_prod   = $signed(r_s1_noise) * $signed({1'b0, r_s1_sigma});
  assign w_sum    = $signed({{17{r_s1_data[15]}}, r_s1_data}) + (w_prod >>> 14);
  assign w_sat_hi = w_sum > 33'sd32767;
  assign w_sat_lo = w_sum < -33'sd32768;
  assign w_res    = w_sat_hi ? 16'h7FFF : (w_sat_lo ? 16'h8000 : w_sum[15:0]);

  // Stage 2: saturated result held until accepted downstream.
  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_sat   <= 1'b0;
    end else if (w_adv2) begin
      out_valid <= r_s1_valid;
      if (r_s1_valid) begin
        out_data <= w_res;
        out_sat  <= w_sat_hi || w_sat_lo;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sat_count <= '0;
    end else if (out_valid && out_ready && out_sat && (sat_count != '1)) begin
      sat_count <= sat_count + CNT_W'(1);
    end
  end

endmodule
`default_nettype wire
